// File: rtl/dvsd_pd_pkg.sv
// dvsd_pd_pkg: shared definitions for the dvsd priority-decoder receive path.
//   PD_CODE_W / PD_OUT_W   encoded-index width and one-hot width (OUT = 1 << CODE)
//   PD_FIFO_DEPTH          default code buffer depth
//   PD_CNT_W               default delivered-word counter width
//   code_t                 encoded index type
//   onehot()               expands a code into its one-hot word
package dvsd_pd_pkg;

    localparam int PD_CODE_W     = 3;
    localparam int PD_OUT_W      = 1 << PD_CODE_W;
    localparam int PD_FIFO_DEPTH = 2;
    localparam int PD_CNT_W      = 8;

    typedef logic [PD_CODE_W-1:0] code_t;

    function automatic logic [PD_OUT_W-1:0] onehot(input code_t code);
        logic [PD_OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/dvsd_pd_fifo.sv
// dvsd_pd_fifo: small synchronous FIFO for encoded indices.
//   clk, rst_n       clock, async active-low reset (empties the buffer)
//   push, wr_data    write request and data (ignored when full without a pop)
//   pop, rd_data     read request and head-of-queue data (combinational)
//   full, empty      occupancy status
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module dvsd_pd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic [W-1:0] mem_r [DEPTH];
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);

    // A pop in the same cycle frees the head slot, so a push into a full buffer is legal then.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
                wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/dvsd_pd_decoder.sv
// dvsd_pd_decoder: receive side of the dvsd priority-encoder link.
//   wb_clk_i, wb_rst_n          clock, async active-low reset
//   code_i, gs_i, eno_i         encoder outputs; gs_i & ~eno_i is a push request
//   in_ready_o                  buffer can take a code this cycle
//   en_i                        decoder enable; low blocks new pops only
//   dec_o, dec_valid_o, dec_ready_i   registered one-hot output handshake
//   pend_o                      sticky OR of delivered words
//   clear_i                     clears pend_o, evt_cnt_o, drop_o, err_o
//   evt_cnt_o                   saturating delivered-word count
//   drop_o, err_o               sticky lost-code / illegal gs+eno flags
module dvsd_pd_decoder
    import dvsd_pd_pkg::*;
#(
    parameter int FIFO_DEPTH = PD_FIFO_DEPTH,
    parameter int CNT_W      = PD_CNT_W
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic [PD_CODE_W-1:0] code_i,
    input  logic                 gs_i,
    input  logic                 eno_i,
    output logic                 in_ready_o,
    input  logic                 en_i,
    output logic [PD_OUT_W-1:0]  dec_o,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [PD_OUT_W-1:0]  pend_o,
    input  logic                 clear_i,
    output logic [CNT_W-1:0]     evt_cnt_o,
    output logic                 drop_o,
    output logic                 err_o
);

    logic                ready_en_r;
    logic [PD_OUT_W-1:0] dec_r;
    logic                dec_valid_r;
    logic [PD_OUT_W-1:0] pend_r;
    logic [CNT_W-1:0]    evt_cnt_r;
    logic                drop_r;
    logic                err_r;

    logic                full_s;
    logic                empty_s;
    code_t               rd_code_s;
    logic                pop_s;
    logic                push_s;
    logic                in_ready_s;
    logic                deliver_s;
    logic [PD_OUT_W-1:0] pend_nxt_s;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic                drop_nxt_s;
    logic                err_nxt_s;

    // Output register may be refilled when it is empty or being drained this cycle.
    assign pop_s      = en_i & ~empty_s & (~dec_valid_r | dec_ready_i);
    // ready_en_r holds in_ready_o low during reset and for the first cycle after release.
    assign in_ready_s = ready_en_r & (~full_s | pop_s);
    assign push_s     = gs_i & ~eno_i & in_ready_s;
    assign deliver_s  = dec_valid_r & dec_ready_i;

    dvsd_pd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PD_CODE_W)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n),
        .push    (push_s),
        .wr_data (code_i),
        .pop     (pop_s),
        .rd_data (rd_code_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Next-state for the sticky status: clear first, then same-cycle events are recorded on top.
    always_comb begin
        pend_nxt_s = clear_i ? '0 : pend_r;
        cnt_nxt_s  = clear_i ? '0 : evt_cnt_r;
        drop_nxt_s = (clear_i ? 1'b0 : drop_r) | (gs_i & ~in_ready_s);
        err_nxt_s  = (clear_i ? 1'b0 : err_r)  | (gs_i & eno_i);
        if (deliver_s) begin
            pend_nxt_s = pend_nxt_s | dec_r;
            if (cnt_nxt_s != {CNT_W{1'b1}}) begin
                cnt_nxt_s = cnt_nxt_s + CNT_W'(1);
            end else begin
                cnt_nxt_s = cnt_nxt_s;
            end
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // Output register, status registers and post-reset ready enable.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ready_en_r  <= 1'b0;
            dec_r       <= '0;
            dec_valid_r <= 1'b0;
            pend_r      <= '0;
            evt_cnt_r   <= '0;
            drop_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (pop_s) begin
                dec_r       <= onehot(rd_code_s);
                dec_valid_r <= 1'b1;
            end else if (deliver_s) begin
                dec_r       <= '0;
                dec_valid_r <= 1'b0;
            end
            pend_r    <= pend_nxt_s;
            evt_cnt_r <= cnt_nxt_s;
            drop_r    <= drop_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign dec_o       = dec_r;
    assign dec_valid_o = dec_valid_r;
    assign pend_o      = pend_r;
    assign evt_cnt_o   = evt_cnt_r;
    assign drop_o      = drop_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_dvsd_pd_decoder.sv
// tb_dvsd_pd_decoder: directed self-checking bench for dvsd_pd_decoder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_dvsd_pd_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] code;
    logic       gs;
    logic       eno;
    logic       in_ready;
    logic       en;
    logic [7:0] dec;
    logic       dec_valid;
    logic       dec_ready;
    logic [7:0] pend;
    logic       clear;
    logic [7:0] evt_cnt;
    logic       drop;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dvsd_pd_decoder dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .code_i      (code),
        .gs_i        (gs),
        .eno_i       (eno),
        .in_ready_o  (in_ready),
        .en_i        (en),
        .dec_o       (dec),
        .dec_valid_o (dec_valid),
        .dec_ready_i (dec_ready),
        .pend_o      (pend),
        .clear_i     (clear),
        .evt_cnt_o   (evt_cnt),
        .drop_o      (drop),
        .err_o       (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] c);
        gs   = 1'b1;
        code = c;
        tick();
        gs   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dec"},   {24'd0, dec},     32'd0);
        check_val({tag, "_valid"}, {31'd0, dec_valid}, 32'd0);
        check_val({tag, "_rdy"},   {31'd0, in_ready}, 32'd0);
        check_val({tag, "_pend"},  {24'd0, pend},    32'd0);
        check_val({tag, "_cnt"},   {24'd0, evt_cnt}, 32'd0);
        check_val({tag, "_drop"},  {31'd0, drop},    32'd0);
        check_val({tag, "_err"},   {31'd0, err},     32'd0);
    endtask

    initial begin
        rst_n = 1'b0; code = 3'd0; gs = 1'b0; eno = 1'b0;
        en = 1'b1; dec_ready = 1'b1; clear = 1'b0;
        #3;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rdy_before_first_edge", {31'd0, in_ready}, 32'd0);
        tick();
        check_val("rdy_after_release", {31'd0, in_ready}, 32'd1);

        // 1: single code 5, latency two cycles
        push(3'd5);
        check_val("t1_valid_n1", {31'd0, dec_valid}, 32'd0);
        tick();
        check_val("t1_valid_n2", {31'd0, dec_valid}, 32'd1);
        check_val("t1_dec",      {24'd0, dec},       32'h20);
        tick();
        check_val("t1_pend",     {24'd0, pend},      32'h20);
        check_val("t1_cnt",      {24'd0, evt_cnt},   32'd1);
        check_val("t1_drained",  {31'd0, dec_valid}, 32'd0);

        // 2: fill buffer while output side stalled; third code is dropped
        en = 1'b0; dec_ready = 1'b0;
        push(3'd3);
        push(3'd0);
        check_val("t2_full_rdy", {31'd0, in_ready}, 32'd0);
        push(3'd7);
        check_val("t2_drop",     {31'd0, drop},     32'd1);
        en = 1'b1; dec_ready = 1'b1;
        tick();
        check_val("t2_word0",    {24'd0, dec},      32'h08);
        tick();
        check_val("t2_word1",    {24'd0, dec},      32'h01);
        tick();
        check_val("t2_no_word2", {31'd0, dec_valid}, 32'd0);
        check_val("t2_pend",     {24'd0, pend},     32'h29);
        check_val("t2_cnt",      {24'd0, evt_cnt},  32'd3);

        // 3: clear, then illegal gs+eno
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("t3_clr_pend", {24'd0, pend},    32'd0);
        check_val("t3_clr_cnt",  {24'd0, evt_cnt}, 32'd0);
        check_val("t3_clr_drop", {31'd0, drop},    32'd0);
        eno = 1'b1;
        push(3'd2);
        eno = 1'b0;
        check_val("t3_err", {31'd0, err}, 32'd1);
        tick(); tick();
        check_val("t3_no_word", {31'd0, dec_valid}, 32'd0);
        check_val("t3_no_drop", {31'd0, drop},      32'd0);

        // 4: counter saturation, then clear with a same-cycle delivery
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("t4_err_clr", {31'd0, err}, 32'd0);
        for (int i = 0; i < 255; i++) begin
            gs = 1'b1; code = 3'(i % 8);
            tick();
        end
        gs = 1'b0;
        tick(); tick(); tick();
        check_val("t4_cnt_255", {24'd0, evt_cnt}, 32'hFF);
        check_val("t4_pend_all", {24'd0, pend},   32'hFF);
        push(3'd4);
        tick(); tick(); tick();
        check_val("t4_cnt_sat", {24'd0, evt_cnt}, 32'hFF);
        push(3'd1);
        tick();
        check_val("t4_word_pending", {31'd0, dec_valid}, 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        check_val("t4_clr_cnt",  {24'd0, evt_cnt}, 32'd1);
        check_val("t4_clr_pend", {24'd0, pend},    32'h02);

        // 5: en low holds buffered codes; release pops them in order, and a push into
        //    the full buffer is taken because of the same-cycle pop
        en = 1'b0;
        push(3'd6);
        push(3'd2);
        tick(); tick();
        check_val("t5_stalled", {31'd0, dec_valid}, 32'd0);
        check_val("t5_full",    {31'd0, in_ready},  32'd0);
        en = 1'b1;
        #1;
        check_val("t5_rdy_pop", {31'd0, in_ready}, 32'd1);
        push(3'd3);
        check_val("t5_w0", {24'd0, dec}, 32'h40);
        tick();
        check_val("t5_w1", {24'd0, dec}, 32'h04);
        tick();
        check_val("t5_w2", {24'd0, dec}, 32'h08);
        check_val("t5_no_drop", {31'd0, drop}, 32'd0);
        tick();
        check_val("t5_done", {31'd0, dec_valid}, 32'd0);

        // 6: reset mid-stream with the buffer full and a word held
        dec_ready = 1'b0;
        push(3'd5);
        push(3'd6);
        push(3'd7);
        check_val("t6_held_valid", {31'd0, dec_valid}, 32'd1);
        check_val("t6_held_dec",   {24'd0, dec},       32'h20);
        check_val("t6_full",       {31'd0, in_ready},  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t6_no_stale", {31'd0, dec_valid}, 32'd0);
        end
        check_val("t6_rdy_back", {31'd0, in_ready}, 32'd1);
        check_val("t6_cnt", {24'd0, evt_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
